// File: rtl/r2r_dac_sched.sv
// rtl/r2r_dac_sched.sv - round-robin code scheduler with slew limit and settle hold in front of the r2r_dac ladder
module r2r_dac_sched #(
    parameter int WIDTH        = 8,
    parameter int NREQ         = 2,
    parameter int DIV_W        = 16,
    parameter int MAX_STEP     = 16,
    parameter int SETTLE_TICKS = 2,
    localparam int GW          = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic [DIV_W-1:0]      div_i,
    input  logic [NREQ-1:0]       req_valid_i,
    input  logic [NREQ*WIDTH-1:0] req_code_i,
    output logic [NREQ-1:0]       req_ready_o,
    output logic [WIDTH-1:0]      dig_o,
    output logic [GW-1:0]         grant_id_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int SW      = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS) : 1;
    localparam int SLAST_I = (SETTLE_TICKS > 0) ? SETTLE_TICKS - 1 : 0;
    localparam logic [SW-1:0]  SLAST = SLAST_I[SW-1:0];
    localparam logic [WIDTH:0] STEP  = MAX_STEP[WIDTH:0];

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RAMP   = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dig_q, dig_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [GW-1:0]    grant_q, grant_d;
    logic [GW-1:0]    ptr_q, ptr_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [SW-1:0]    scnt_q, scnt_d;
    logic             done_q, done_d;

    logic             busy_st;
    logic             tick;
    logic             found;
    logic [GW-1:0]    g_sel;
    logic [WIDTH:0]   t_ext;
    logic [WIDTH:0]   d_ext;
    logic [WIDTH:0]   diff;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            dig_q    <= '0;
            target_q <= '0;
            grant_q  <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            scnt_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dig_q    <= dig_d;
            target_q <= target_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            scnt_q   <= scnt_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        dig_d       = dig_q;
        target_d    = target_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        scnt_d      = scnt_q;
        done_d      = 1'b0;
        req_ready_o = '0;
        found       = 1'b0;
        g_sel       = '0;

        // First valid requester at or after the round-robin pointer, cyclically.
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid_i[(int'(ptr_q) + i) % NREQ]) begin
                found = 1'b1;
                g_sel = GW'((int'(ptr_q) + i) % NREQ);
            end
        end

        busy_st = (state_q != S_IDLE);
        tick    = en_i && busy_st && (cnt_q >= div_i);
        if (en_i && busy_st) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end

        t_ext = {1'b0, target_q};
        d_ext = {1'b0, dig_q};
        diff  = (t_ext >= d_ext) ? (t_ext - d_ext) : (d_ext - t_ext);

        unique case (state_q)
            S_IDLE: begin
                // Ready is masked during reset so no requester sees a false accept.
                if (en_i && found && !rst) begin
                    req_ready_o[g_sel] = 1'b1;
                    target_d = req_code_i[g_sel*WIDTH +: WIDTH];
                    grant_d  = g_sel;
                    ptr_d    = (int'(g_sel) == NREQ - 1) ? '0 : g_sel + 1'b1;
                    cnt_d    = '0;
                    state_d  = S_RAMP;
                end
            end
            S_RAMP: begin
                if (tick) begin
                    if (MAX_STEP == 0 || diff <= STEP) begin
                        dig_d   = target_q;
                        scnt_d  = '0;
                        state_d = S_SETTLE;
                    end else if (t_ext > d_ext) begin
                        dig_d = dig_q + STEP[WIDTH-1:0];
                    end else begin
                        dig_d = dig_q - STEP[WIDTH-1:0];
                    end
                end
            end
            S_SETTLE: begin
                if (en_i) begin
                    if (SETTLE_TICKS == 0) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else if (tick) begin
                        if (scnt_q == SLAST) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            scnt_d = scnt_q + 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign dig_o      = dig_q;
    assign grant_id_o = grant_q;
    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = done_q;

endmodule

// File: tb/tb_r2r_dac_sched.sv
// tb/tb_r2r_dac_sched.sv - self-checking bench for r2r_dac_sched
module tb_r2r_dac_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_b, en_b;
    logic [15:0] div_b;
    logic [1:0]  vld_b;
    logic [15:0] code_b;
    logic [1:0]  rdy_b;
    logic [7:0]  dig_b;
    logic        gid_b, busy_b, done_b;

    logic        rst_a, en_a;
    logic [15:0] div_a;
    logic [1:0]  vld_a;
    logic [15:0] code_a;
    logic [1:0]  rdy_a;
    logic [7:0]  dig_a;
    logic        gid_a, busy_a, done_a;

    r2r_dac_sched u_dut_b (
        .clk(clk), .rst(rst_b), .en_i(en_b), .div_i(div_b),
        .req_valid_i(vld_b), .req_code_i(code_b), .req_ready_o(rdy_b),
        .dig_o(dig_b), .grant_id_o(gid_b), .busy_o(busy_b), .done_o(done_b)
    );

    r2r_dac_sched #(.MAX_STEP(0)) u_dut_a (
        .clk(clk), .rst(rst_a), .en_i(en_a), .div_i(div_a),
        .req_valid_i(vld_a), .req_code_i(code_a), .req_ready_o(rdy_a),
        .dig_o(dig_a), .grant_id_o(gid_a), .busy_o(busy_a), .done_o(done_a)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] valid;
        logic [7:0] code0;
        logic [1:0] exp_ready;
        logic [7:0] exp_dig;
        logic       exp_busy;
        logic       exp_done;
    } vec_t;

    typedef struct {
        logic       gid;
        logic [7:0] code;
    } exp_t;

    vec_t tbl[16];
    exp_t done_exp[$];
    int   gnt_exp[$];

    task automatic reset_b();
        rst_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_b = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        int   g;

        tbl[0]  = '{2'b01, 8'h50, 2'b01, 8'h00, 1'b1, 1'b0};
        tbl[1]  = '{2'b00, 8'h50, 2'b00, 8'h10, 1'b1, 1'b0};
        tbl[2]  = '{2'b00, 8'h50, 2'b00, 8'h20, 1'b1, 1'b0};
        tbl[3]  = '{2'b00, 8'h50, 2'b00, 8'h30, 1'b1, 1'b0};
        tbl[4]  = '{2'b00, 8'h50, 2'b00, 8'h40, 1'b1, 1'b0};
        tbl[5]  = '{2'b00, 8'h50, 2'b00, 8'h50, 1'b1, 1'b0};
        tbl[6]  = '{2'b00, 8'h50, 2'b00, 8'h50, 1'b1, 1'b0};
        tbl[7]  = '{2'b01, 8'h05, 2'b00, 8'h50, 1'b0, 1'b1};
        tbl[8]  = '{2'b01, 8'h05, 2'b01, 8'h50, 1'b1, 1'b0};
        tbl[9]  = '{2'b00, 8'h05, 2'b00, 8'h40, 1'b1, 1'b0};
        tbl[10] = '{2'b00, 8'h05, 2'b00, 8'h30, 1'b1, 1'b0};
        tbl[11] = '{2'b00, 8'h05, 2'b00, 8'h20, 1'b1, 1'b0};
        tbl[12] = '{2'b00, 8'h05, 2'b00, 8'h10, 1'b1, 1'b0};
        tbl[13] = '{2'b00, 8'h05, 2'b00, 8'h05, 1'b1, 1'b0};
        tbl[14] = '{2'b00, 8'h05, 2'b00, 8'h05, 1'b1, 1'b0};
        tbl[15] = '{2'b00, 8'h05, 2'b00, 8'h05, 1'b0, 1'b1};

        rst_b = 1'b1; en_b = 1'b1; div_b = 16'd0; vld_b = 2'b11; code_b = 16'h2211;
        rst_a = 1'b1; en_a = 1'b1; div_a = 16'd3; vld_a = 2'b11; code_a = 16'h2211;

        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            chk("rst_dig", dig_b, 8'h00);
            chk("rst_ready", rdy_b, 2'b00);
            chk("rst_busy", busy_b, 1'b0);
            chk("rst_done", done_b, 1'b0);
            chk("rst_gid", gid_b, 1'b0);
            chk("rst_ready_a", rdy_a, 2'b00);
        end
        rst_b = 1'b0; rst_a = 1'b0; vld_a = 2'b00;

        for (int v = 0; v < 16; v++) begin
            vld_b  = tbl[v].valid;
            code_b = {8'h00, tbl[v].code0};
            #1;
            chk($sformatf("tbl%0d_ready", v), rdy_b, tbl[v].exp_ready);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("tbl%0d_dig", v), dig_b, tbl[v].exp_dig);
            chk($sformatf("tbl%0d_busy", v), busy_b, tbl[v].exp_busy);
            chk($sformatf("tbl%0d_done", v), done_b, tbl[v].exp_done);
            chk($sformatf("tbl%0d_gid", v), gid_b, 1'b0);
        end
        vld_b = 2'b00;

        vld_a  = 2'b01;
        code_a = 16'h00A5;
        #1;
        chk("nolim_ready", rdy_a, 2'b01);
        @(posedge clk);
        @(negedge clk);
        vld_a = 2'b00;
        chk("nolim_e0_busy", busy_a, 1'b1);
        for (int k = 1; k <= 13; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("nolim_e%0d_dig", k), dig_a, (k >= 4) ? 8'hA5 : 8'h00);
            chk($sformatf("nolim_e%0d_done", k), done_a, (k == 12) ? 1'b1 : 1'b0);
            chk($sformatf("nolim_e%0d_busy", k), busy_a, (k < 12) ? 1'b1 : 1'b0);
        end

        reset_b();
        div_b  = 16'd0;
        vld_b  = 2'b11;
        code_b = 16'h2211;
        for (int k = 0; k < 4; k++) begin
            e.gid  = k[0];
            e.code = k[0] ? 8'h22 : 8'h11;
            done_exp.push_back(e);
            gnt_exp.push_back(k % 2);
        end
        for (int cyc = 0; cyc < 200 && done_exp.size() > 0; cyc++) begin
            #1;
            if (rdy_b != 2'b00) begin
                if (gnt_exp.size() == 0) begin
                    chk("rr_extra_ready", rdy_b, 2'b00);
                end else begin
                    g = gnt_exp.pop_front();
                    chk("rr_ready", rdy_b, 32'd1 << g);
                end
            end
            @(posedge clk);
            @(negedge clk);
            if (done_b) begin
                e = done_exp.pop_front();
                chk("rr_dig", dig_b, e.code);
                chk("rr_gid", gid_b, e.gid);
            end
        end
        if (done_exp.size() != 0) chk("rr_timeout", done_exp.size(), 0);
        if (gnt_exp.size() != 0) chk("rr_missing_grant", gnt_exp.size(), 0);
        vld_b = 2'b00;

        reset_b();
        div_b  = 16'd3;
        vld_b  = 2'b01;
        code_b = 16'h0050;
        #1;
        chk("frz_ready", rdy_b, 2'b01);
        @(posedge clk);
        @(negedge clk);
        vld_b = 2'b00;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("frz_pre%0d_dig", k), dig_b, (k >= 4) ? 8'h10 : 8'h00);
        end
        en_b = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("frz_hold%0d_dig", k), dig_b, 8'h10);
            chk($sformatf("frz_hold%0d_busy", k), busy_b, 1'b1);
            chk($sformatf("frz_hold%0d_done", k), done_b, 1'b0);
        end
        en_b = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("frz_resume%0d_dig", k), dig_b, (k == 3) ? 8'h20 : 8'h10);
        end
        rst_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_b = 1'b0;
        chk("midrst_dig", dig_b, 8'h00);
        chk("midrst_busy", busy_b, 1'b0);
        chk("midrst_gid", gid_b, 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("postrst%0d_dig", k), dig_b, 8'h00);
            chk($sformatf("postrst%0d_busy", k), busy_b, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
